// File: rtl/activation_stream_fif_if.sv
// Valid/ready activation stream bundle around the buffer.
// The slave modport is the buffer's view and the master modport is the environment's view.
interface activation_stream_if #(
  parameter int Channels        = 8,
  parameter int ActivationWidth = 8,
  parameter int Depth           = 16
);
  localparam int DataW  = Channels * ActivationWidth;
  localparam int CountW = $clog2(Depth + 1);

  logic              slave_valid_i;
  logic              slave_ready_o;
  logic [DataW-1:0]  slave_data_i;
  logic              master_valid_o;
  logic              master_ready_i;
  logic [DataW-1:0]  master_data_o;
  logic              master_first_o;
  logic              master_last_o;
  logic              master_end_of_frame_o;
  logic [CountW-1:0] count_o;

  modport slave (
    input  slave_valid_i, slave_data_i, master_ready_i,
    output slave_ready_o, master_valid_o, master_data_o,
           master_first_o, master_last_o, master_end_of_frame_o, count_o
  );

  modport master (
    output slave_valid_i, slave_data_i, master_ready_i,
    input  slave_ready_o, master_valid_o, master_data_o,
           master_first_o, master_last_o, master_end_of_frame_o, count_o
  );
endinterface

// File: rtl/activation_stream_fifo.sv
// First-word-fall-through elastic buffer for activation words, with frame position tracking
// on the output side and an optional storage-free passthrough build.
module activation_stream_fifo #(
  parameter int Channels        = 8,
  parameter int ActivationWidth = 8,
  parameter int Depth           = 16,
  parameter int Height          = 600,
  parameter int Width           = 800,
  parameter int Passthrough     = 0
) (
  input logic                clock_i,
  input logic                reset_i,
  activation_stream_if.slave stream
);
  localparam int DataW  = Channels * ActivationWidth;
  localparam int AddrW  = $clog2(Depth);
  localparam int PtrW   = AddrW + 1;
  localparam int CountW = $clog2(Depth + 1);
  localparam int RowW   = (Height > 1) ? $clog2(Height) : 1;
  localparam int ColW   = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [RowW-1:0] LastRow = RowW'(Height - 1);
  localparam logic [ColW-1:0] LastCol = ColW'(Width - 1);

  logic            pop_s;
  logic [RowW-1:0] row_r;
  logic [ColW-1:0] col_r;

  assign pop_s = stream.master_valid_o & stream.master_ready_i;

  // Pixel position of the head word, advanced on every accepted output word.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      row_r <= '0;
      col_r <= '0;
    end else if (pop_s) begin
      if (col_r == LastCol) begin
        col_r <= '0;
        if (row_r == LastRow) begin
          row_r <= '0;
        end else begin
          row_r <= row_r + RowW'(1);
        end
      end else begin
        col_r <= col_r + ColW'(1);
      end
    end else begin
      row_r <= row_r;
      col_r <= col_r;
    end
  end

  assign stream.master_first_o        = (row_r == '0) && (col_r == '0);
  assign stream.master_last_o         = (col_r == LastCol);
  assign stream.master_end_of_frame_o = (row_r == LastRow) && (col_r == LastCol);

  generate
    if (Passthrough != 0) begin : g_pass
      // Reset is folded in so both sides see an idle link while it is held.
      assign stream.master_valid_o = stream.slave_valid_i & reset_i;
      assign stream.slave_ready_o  = stream.master_ready_i & reset_i;
      assign stream.master_data_o  = stream.slave_data_i;
      assign stream.count_o        = '0;
    end else begin : g_fifo
      logic [DataW-1:0]  mem_r [Depth];
      logic [PtrW-1:0]   wr_ptr_r;
      logic [PtrW-1:0]   rd_ptr_r;
      logic [CountW-1:0] count_r;
      logic              full_s;
      logic              push_s;

      assign full_s = (wr_ptr_r[AddrW] != rd_ptr_r[AddrW]) &&
                      (wr_ptr_r[AddrW-1:0] == rd_ptr_r[AddrW-1:0]);
      // Ready depends only on state and reset, never on the downstream ready.
      assign stream.slave_ready_o  = reset_i & ~full_s;
      assign push_s                = stream.slave_valid_i & stream.slave_ready_o;
      assign stream.master_valid_o = (count_r != '0);
      assign stream.master_data_o  = mem_r[rd_ptr_r[AddrW-1:0]];
      assign stream.count_o        = count_r;

      // Storage array; contents survive reset and are simply ignored afterwards.
      always_ff @(posedge clock_i) begin
        if (push_s) begin
          mem_r[wr_ptr_r[AddrW-1:0]] <= stream.slave_data_i;
        end
      end

      // Pointer and occupancy bookkeeping.
      always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
          wr_ptr_r <= '0;
          rd_ptr_r <= '0;
          count_r  <= '0;
        end else begin
          if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PtrW'(1);
          end
          if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PtrW'(1);
          end
          case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CountW'(1);
            2'b01:   count_r <= count_r - CountW'(1);
            default: count_r <= count_r;
          endcase
        end
      end
    end
  endgenerate
endmodule
